// File: rtl/class_hvec_pkg.sv
// -----------------------------------------------------------------------------
// class_hvec_pkg
// Shared definitions for the class-hypervector store:
//   - default geometry of the store (classes, frames per class, frame width)
//   - encoding of the frame update operation driven on wr_op
//   - state type of the read-streaming FSM
// -----------------------------------------------------------------------------
package class_hvec_pkg;

  localparam int DEF_NUM_CLASSES = 8;
  localparam int DEF_NUM_FRAMES  = 3;
  localparam int DEF_FRAME_W     = 64;

  // Frame update operations
  localparam logic [1:0] WR_OVR = 2'b00;  // overwrite with operand
  localparam logic [1:0] WR_SET = 2'b01;  // OR: set operand bits
  localparam logic [1:0] WR_TGL = 2'b10;  // XOR: toggle operand bits
  localparam logic [1:0] WR_CLR = 2'b11;  // AND-NOT: clear operand bits

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/hvec_frame_update.sv
// -----------------------------------------------------------------------------
// hvec_frame_update
// Combinational bit-level update of one hypervector frame.
// Ports:
//   op        in  2        update operation (WR_OVR/WR_SET/WR_TGL/WR_CLR)
//   old_frame in  FRAME_W  current stored frame
//   operand   in  FRAME_W  update operand
//   new_frame out FRAME_W  frame value after the update
// -----------------------------------------------------------------------------
module hvec_frame_update
  import class_hvec_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W
) (
  input  logic [1:0]         op,
  input  logic [FRAME_W-1:0] old_frame,
  input  logic [FRAME_W-1:0] operand,
  output logic [FRAME_W-1:0] new_frame
);

  always_comb begin
    new_frame = old_frame;
    case (op)
      WR_OVR: new_frame = operand;
      WR_SET: new_frame = old_frame | operand;
      WR_TGL: new_frame = old_frame ^ operand;
      WR_CLR: new_frame = old_frame & ~operand;
    endcase
  end

endmodule

// File: rtl/class_hvec_store.sv
// -----------------------------------------------------------------------------
// class_hvec_store
// Writable store of NUM_CLASSES class hypervectors, each NUM_FRAMES frames of
// FRAME_W bits. A requested class is streamed frame-by-frame over a
// valid/ready interface; the training path updates single frames in place.
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   clr        in   1        synchronous clear of all storage, aborts a stream
//   req_valid  in   1        read request valid
//   req_ready  out  1        store idle, request can be accepted
//   req_class  in   CLS_W    class to stream
//   out_valid  out  1        frame valid
//   out_ready  in   1        consumer accepts frame
//   out_data   out  FRAME_W  frame contents
//   out_class  out  CLS_W    class of current frame
//   out_fidx   out  FIDX_W   index of current frame
//   out_last   out  1        current frame is the final frame of the class
//   req_err    out  1        pulse: out-of-range class requested
//   wr_en      in   1        frame update strobe
//   wr_op      in   2        update operation (see class_hvec_pkg)
//   wr_class   in   CLS_W    target class
//   wr_fidx    in   FIDX_W   target frame
//   wr_data    in   FRAME_W  update operand
//   wr_err     out  1        pulse: out-of-range write dropped
// -----------------------------------------------------------------------------
module class_hvec_store
  import class_hvec_pkg::*;
#(
  parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter  int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter  int FRAME_W     = DEF_FRAME_W,
  localparam int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int FIDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CLS_W-1:0]   req_class,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] out_data,
  output logic [CLS_W-1:0]   out_class,
  output logic [FIDX_W-1:0]  out_fidx,
  output logic               out_last,
  output logic               req_err,
  input  logic               wr_en,
  input  logic [1:0]         wr_op,
  input  logic [CLS_W-1:0]   wr_class,
  input  logic [FIDX_W-1:0]  wr_fidx,
  input  logic [FRAME_W-1:0] wr_data,
  output logic               wr_err
);

  localparam logic SINGLE_FRAME = (NUM_FRAMES == 1);

  logic [FRAME_W-1:0] mem [NUM_CLASSES][NUM_FRAMES];
  state_t             state;

  logic               req_in_range;
  logic               wr_in_range;
  logic [FIDX_W-1:0]  nxt_fidx;
  logic               nxt_last;
  logic [FRAME_W-1:0] upd_frame;

  // Indices are widened, never truncated, before the range check so that
  // non-power-of-two class/frame counts reject the unused codes.
  assign req_in_range = (32'(req_class) < NUM_CLASSES);
  assign wr_in_range  = (32'(wr_class) < NUM_CLASSES) && (32'(wr_fidx) < NUM_FRAMES);

  assign nxt_fidx  = out_fidx + FIDX_W'(1);
  assign nxt_last  = (32'(nxt_fidx) == NUM_FRAMES - 1);
  assign req_ready = (state == ST_IDLE);

  hvec_frame_update #(
    .FRAME_W (FRAME_W)
  ) u_update (
    .op        (wr_op),
    .old_frame (mem[wr_class][wr_fidx]),
    .operand   (wr_data),
    .new_frame (upd_frame)
  );

  // Storage write port. Runs independently of the read FSM; reads in the FSM
  // sample the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int f = 0; f < NUM_FRAMES; f++)
          mem[c][f] <= '0;
      wr_err <= 1'b0;
    end else if (clr) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int f = 0; f < NUM_FRAMES; f++)
          mem[c][f] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      if (wr_en) begin
        if (wr_in_range)
          mem[wr_class][wr_fidx] <= upd_frame;
        else
          wr_err <= 1'b1;
      end
    end
  end

  // Read streaming FSM with registered output frame. Each frame is loaded on
  // the edge that accepts the request or hands off the previous frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_class <= '0;
      out_fidx  <= '0;
      out_last  <= 1'b0;
      req_err   <= 1'b0;
    end else if (clr) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_class <= '0;
      out_fidx  <= '0;
      out_last  <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      req_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_in_range) begin
              state     <= ST_STREAM;
              out_valid <= 1'b1;
              out_class <= req_class;
              out_fidx  <= '0;
              out_data  <= mem[req_class][0];
              out_last  <= SINGLE_FRAME;
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end else begin
              out_fidx <= nxt_fidx;
              out_data <= mem[out_class][nxt_fidx];
              out_last <= nxt_last;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_class_hvec_store.sv
// -----------------------------------------------------------------------------
// tb_class_hvec_store
// Scoreboard bench for class_hvec_store. The stimulus process keeps a plain
// array model of the store and, whenever a frame is due to be presented,
// pushes that frame into an expectation queue. A negedge monitor compares the
// presented frame against the queue head and pops it on handshake.
// A non-power-of-two class count (6) is used so out-of-range classes can
// actually be driven on the 3-bit class ports.
// -----------------------------------------------------------------------------
module tb_class_hvec_store;
  import class_hvec_pkg::*;

  localparam int NC  = 6;
  localparam int NF  = 3;
  localparam int FW  = 64;
  localparam int CW  = 3;
  localparam int FIW = 2;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_class;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_data;
  logic [CW-1:0] out_class;
  logic [FIW-1:0] out_fidx;
  logic          out_last;
  logic          req_err;
  logic          wr_en;
  logic [1:0]    wr_op;
  logic [CW-1:0] wr_class;
  logic [FIW-1:0] wr_fidx;
  logic [FW-1:0] wr_data;
  logic          wr_err;

  class_hvec_store #(
    .NUM_CLASSES (NC),
    .NUM_FRAMES  (NF),
    .FRAME_W     (FW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_class (req_class),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_class (out_class),
    .out_fidx  (out_fidx),
    .out_last  (out_last),
    .req_err   (req_err),
    .wr_en     (wr_en),
    .wr_op     (wr_op),
    .wr_class  (wr_class),
    .wr_fidx   (wr_fidx),
    .wr_data   (wr_data),
    .wr_err    (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] data;
    int            cls;
    int            fidx;
    bit            last;
  } frame_t;

  frame_t        exp_q[$];
  logic [FW-1:0] ref_mem [NC][NF];
  bit            m_busy;
  int            m_cls;
  int            m_next;
  bit            exp_req_err;
  bit            exp_wr_err;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(string name, logic [FW-1:0] act, logic [FW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [FW-1:0] refOp(logic [1:0] op, logic [FW-1:0] o, logic [FW-1:0] d);
    case (op)
      WR_OVR:  return d;
      WR_SET:  return o | d;
      WR_TGL:  return o ^ d;
      default: return o & ~d;
    endcase
  endfunction

  task automatic resetModel();
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++)
        ref_mem[c][f] = '0;
    exp_q.delete();
    m_busy      = 1'b0;
    m_cls       = 0;
    m_next      = 0;
    exp_req_err = 1'b0;
    exp_wr_err  = 1'b0;
  endtask

  task automatic pushFrame(int c, int f);
    frame_t e;
    e.data = ref_mem[c][f];
    e.cls  = c;
    e.fidx = f;
    e.last = (f == NF - 1);
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs, take the edge, then advance the model with
  // the values that were present at that edge. Frames are snapshotted before
  // the same-edge write is applied to the model.
  task automatic applyStimulus(bit rv, int rc, bit rdy, bit we, logic [1:0] op,
                               int wc, int wf, logic [FW-1:0] wd, bit cl);
    req_valid = rv;
    req_class = CW'(rc);
    out_ready = rdy;
    wr_en     = we;
    wr_op     = op;
    wr_class  = CW'(wc);
    wr_fidx   = FIW'(wf);
    wr_data   = wd;
    clr       = cl;
    @(posedge clk);
    exp_req_err = 1'b0;
    exp_wr_err  = 1'b0;
    if (cl) begin
      for (int c = 0; c < NC; c++)
        for (int f = 0; f < NF; f++)
          ref_mem[c][f] = '0;
      exp_q.delete();
      m_busy = 1'b0;
    end else begin
      if (m_busy) begin
        if (rdy) begin
          if (m_next == NF) begin
            m_busy = 1'b0;
          end else begin
            pushFrame(m_cls, m_next);
            m_next++;
          end
        end
      end else if (rv) begin
        if (rc < NC) begin
          m_busy = 1'b1;
          m_cls  = rc;
          m_next = 1;
          pushFrame(rc, 0);
        end else begin
          exp_req_err = 1'b1;
        end
      end
      if (we) begin
        if (wc < NC && wf < NF)
          ref_mem[wc][wf] = refOp(op, ref_mem[wc][wf], wd);
        else
          exp_wr_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 0, 1'b1, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
  endtask

  task automatic writeFrame(logic [1:0] op, int c, int f, logic [FW-1:0] d);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, op, c, f, d, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_busy && guard < 20) begin
      idle(1);
      guard++;
    end
    checks++;
    if (m_busy) begin
      errors++;
      $display("[TB] FAIL stream_timeout: stream still busy after %0d cycles", guard);
    end
  endtask

  task automatic streamClass(int c);
    applyStimulus(1'b1, c, 1'b1, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    drain();
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      frame_t e;
      checkOutput("out_valid", FW'(out_valid), FW'(exp_q.size() != 0));
      checkOutput("req_ready", FW'(req_ready), FW'(!m_busy));
      checkOutput("req_err", FW'(req_err), FW'(exp_req_err));
      checkOutput("wr_err", FW'(wr_err), FW'(exp_wr_err));
      if (out_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_class", FW'(out_class), FW'(e.cls));
        checkOutput("out_fidx", FW'(out_fidx), FW'(e.fidx));
        checkOutput("out_last", FW'(out_last), FW'(e.last));
        if (out_ready)
          void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    req_valid = 1'b0;
    req_class = '0;
    out_ready = 1'b0;
    wr_en     = 1'b0;
    wr_op     = WR_OVR;
    wr_class  = '0;
    wr_fidx   = '0;
    wr_data   = '0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", FW'(out_valid), '0);
    checkOutput("reset out_data", out_data, '0);
    checkOutput("reset req_err", FW'(req_err), '0);
    checkOutput("reset wr_err", FW'(wr_err), '0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] stream class 0 after reset");
    streamClass(0);
    idle(2);

    $display("[TB] overwrite then read");
    writeFrame(WR_OVR, 3, 1, 64'h0000_2000_0020_0000);
    streamClass(3);

    $display("[TB] set/toggle/clear sequence");
    writeFrame(WR_SET, 4, 0, 64'h10);
    writeFrame(WR_TGL, 4, 0, 64'h11);
    writeFrame(WR_CLR, 4, 0, 64'h01);
    streamClass(4);

    $display("[TB] backpressure on frame 1");
    applyStimulus(1'b1, 3, 1'b1, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 0, 1'b0, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    drain();

    $display("[TB] writes during a stream");
    applyStimulus(1'b1, 1, 1'b0, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, WR_OVR, 1, 2, 64'h8000_0000_0000_0000, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, WR_OVR, 1, 0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    drain();
    streamClass(1);

    $display("[TB] out-of-range request and write");
    applyStimulus(1'b1, 6, 1'b1, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    applyStimulus(1'b1, 7, 1'b1, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    idle(1);
    writeFrame(WR_OVR, 2, 3, '1);
    writeFrame(WR_SET, 7, 0, '1);
    idle(1);
    streamClass(2);

    $display("[TB] clear mid-stream with concurrent write/request");
    writeFrame(WR_OVR, 5, 2, 64'hA5A5_5A5A_FFFF_0001);
    applyStimulus(1'b1, 3, 1'b1, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    applyStimulus(1'b1, 2, 1'b1, 1'b1, WR_SET, 0, 0, '1, 1'b1);
    applyStimulus(1'b1, 7, 1'b1, 1'b1, WR_SET, 0, 3, '1, 1'b1);
    for (int c = 0; c < NC; c++)
      streamClass(c);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++)
      applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), {$urandom, $urandom},
                    $urandom_range(0, 59) == 0);
    drain();
    for (int c = 0; c < NC; c++)
      streamClass(c);

    $display("[TB] asynchronous reset mid-stream");
    writeFrame(WR_OVR, 0, 0, 64'h1234_5678_9ABC_DEF0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0, WR_OVR, 0, 0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", FW'(out_valid), '0);
    checkOutput("async reset out_data", out_data, '0);
    checkOutput("async reset out_fidx", FW'(out_fidx), '0);
    checkOutput("async reset out_last", FW'(out_last), '0);
    resetModel();
    req_valid = 1'b0;
    wr_en     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    streamClass(0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
